// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with byte FIFO on the picorv32 native bus.
// TXDATA at +0 pushes a byte, STATUS at +4 reports full/busy/count; a full FIFO stalls mem_ready.
module uart_tx_mmio #(
    parameter int          CLK_HZ     = 100000000,
    parameter int          BAUD       = 115200,
    parameter logic [31:0] BASE_ADDR  = 32'h10000000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_sel,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        uart_tx
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int BW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q;
    logic [BW-1:0]   baud_q;
    logic [2:0]      bit_q;
    logic [7:0]      sh_q;
    logic            tx_q;
    logic [7:0]      fifo_q [FIFO_DEPTH];
    logic [AW-1:0]   wp_q, rp_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            hit, full, empty, push_req, push, pop, baud_end, busy;
    logic            unused_ok;

    assign hit      = mem_valid && (mem_addr[31:3] == BASE_ADDR[31:3]);
    assign full     = cnt_q == CW'(FIFO_DEPTH);
    assign empty    = cnt_q == '0;
    assign push_req = hit & ~mem_addr[2] & mem_wstrb[0];
    // A push into a full FIFO is held off by withholding the acknowledge.
    assign ready_d  = hit & ~ready_q & ~(push_req & full);
    assign push     = ready_d & push_req;
    assign baud_end = baud_q == BW'(DIV - 1);
    assign pop      = ~empty & ((state_q == IDLE) | ((state_q == STOP) & baud_end));
    assign cnt_d    = cnt_q + CW'(push) - CW'(pop);
    assign busy     = ~empty | (state_q != IDLE);
    assign rdata_d  = (ready_d & mem_addr[2] & ~|mem_wstrb) ? {15'd0, 9'(cnt_q), 6'd0, busy, full} : '0;
    assign unused_ok = ^{mem_addr[1:0], mem_wdata[31:8], mem_wstrb[3:1]};

    assign mem_sel   = hit;
    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign uart_tx   = tx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            if (push) wp_q <= wp_q + AW'(1);
            if (pop) rp_q <= rp_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wp_q] <= mem_wdata[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            if (state_q != IDLE) baud_q <= baud_end ? '0 : baud_q + BW'(1);
            case (state_q)
                IDLE: if (pop) begin
                    state_q <= START;
                    sh_q    <= fifo_q[rp_q];
                    tx_q    <= 1'b0;
                end
                START: if (baud_end) begin
                    state_q <= DATA;
                    bit_q   <= '0;
                    tx_q    <= sh_q[0];
                end
                DATA: if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        bit_q <= bit_q + 3'd1;
                        sh_q  <= sh_q >> 1;
                        tx_q  <= sh_q[1];
                    end
                end
                STOP: if (baud_end) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (pop) begin
                        state_q <= START;
                        sh_q    <= fifo_q[rp_q];
                        tx_q    <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: scoreboard bench; bytes written to TXDATA are queued and checked against
// cycle-exact frames decoded from uart_tx, plus handshake, STATUS and reset checks.
module tb_uart_tx_mmio;
    localparam logic [31:0] BASE = 32'h10000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_sel, mem_ready, uart_tx;
    logic [31:0] mem_rdata;

    uart_tx_mmio #(.CLK_HZ(1000), .BAUD(100), .BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_sel(mem_sel),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int n_push = 0;
    int n_frames = 0;
    bit mon_en = 1'b0;
    logic last_sel;
    logic [7:0] sb[$];
    int fall_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st,
                       output logic [31:0] rd, output int ack, output int lat);
        int start;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wd;
        mem_wstrb = st;
        start = cyc;
        ack = -1;
        rd = '0;
        #1 last_sel = mem_sel;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                ack = cyc;
                rd = mem_rdata;
                break;
            end
        end
        mem_valid = 1'b0;
        mem_wstrb = '0;
        lat = ack - start;
        if (ack < 0) check("bus_timeout", 1, 0);
        else if (!addr[2] && st[0] && mon_en) begin
            sb.push_back(wd[7:0]);
            n_push++;
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [7:0] d, output int ack, output int lat);
        logic [31:0] rd;
        bus(addr, {24'd0, d}, 4'hF, rd, ack, lat);
    endtask

    task automatic rd_status(output logic [31:0] v);
        int a, l;
        bus(BASE + 4, '0, 4'h0, v, a, l);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 3000 && n_frames != n_push; i++) @(negedge clk);
        if (n_frames != n_push) check("drain_timeout", n_frames, n_push);
    endtask

    // Line monitor: decodes each frame cycle by cycle against the oldest queued byte.
    initial begin
        logic prev, bad;
        logic [7:0] e, obs;
        logic [9:0] fr;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev && !uart_tx) begin
                fall_q.push_back(cyc);
                if (sb.size() == 0) begin
                    check("frame_unexpected", 1, 0);
                    e = 8'h00;
                end else e = sb.pop_front();
                fr = {1'b1, e, 1'b0};
                bad = 1'b0;
                obs = '0;
                for (int k = 0; k < 100; k++) begin
                    if (k > 0) @(negedge clk);
                    if (uart_tx !== fr[k/10]) bad = 1'b1;
                    if (k % 10 == 5 && k / 10 >= 1 && k / 10 <= 8) obs[k/10-1] = uart_tx;
                end
                check("frame_byte", {24'd0, obs}, {24'd0, e});
                check("frame_shape", {31'd0, bad}, 0);
                n_frames++;
            end
            prev = uart_tx;
        end
    end

    initial begin
        int a, l, l6;
        logic [31:0] v;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, uart_tx}, 1);
        check("rst_ready", {31'd0, mem_ready}, 0);
        check("rst_rdata", mem_rdata, 0);
        rst = 1'b0;

        // Reset asserted mid-frame truncates the frame immediately.
        wr(BASE, 8'h55, a, l);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_tx", {31'd0, uart_tx}, 1);
        check("midrst_ready", {31'd0, mem_ready}, 0);
        @(negedge clk);
        rst = 1'b0;
        rd_status(v);
        check("midrst_status", v, 0);
        check("sel_hit", {31'd0, last_sel}, 1);
        repeat (120) @(negedge clk);
        check("midrst_line_idle", {31'd0, uart_tx}, 1);
        mon_en = 1'b1;

        // Single byte: one-cycle ack latency, start bit the cycle after the ack.
        fall_q.delete();
        wr(BASE, 8'h55, a, l);
        check("t2_latency", l, 1);
        @(negedge clk);
        check("t2_ready_pulse", {31'd0, mem_ready}, 0);
        drain();
        check("t2_fall", fall_q.size() > 0 ? fall_q[0] : -1, a + 1);

        // Back-to-back bytes: no idle gap between frames.
        fall_q.delete();
        wr(BASE, 8'hA5, a, l);
        wr(BASE, 8'h3C, a, l);
        drain();
        check("t3_gap", fall_q.size() == 2 ? fall_q[1] - fall_q[0] : -1, 100);

        // FIFO fill: first byte goes to shifter, next four fill the FIFO, sixth stalls.
        for (int i = 0; i < 5; i++) wr(BASE, 8'(8'h10 + i * 8'h21), a, l);
        rd_status(v);
        check("t4_status_full", v, 32'h0000_0403);
        wr(BASE, 8'hC3, a, l6);
        check("t4_stall", {31'd0, l6 > 50}, 1);
        drain();

        // STATUS during transmission; writes to STATUS are acked and ignored.
        wr(BASE, 8'h11, a, l);
        wr(BASE, 8'h22, a, l);
        rd_status(v);
        check("t5_status", v, 32'h0000_0102);
        wr(BASE + 4, 8'hFF, a, l);
        check("t5_status_wr_ack", {31'd0, a >= 0}, 1);
        rd_status(v);
        check("t5_status_after", v, 32'h0000_0102);
        drain();

        // Out-of-window access and a write without wstrb[0].
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = BASE + 8;
        mem_wdata = 32'h99;
        mem_wstrb = 4'hF;
        #1 check("t6_oow_sel", {31'd0, mem_sel}, 0);
        l = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_ready) l = 1;
        end
        mem_valid = 1'b0;
        mem_wstrb = '0;
        check("t6_oow_ready", l, 0);
        bus(BASE, 32'h77, 4'b0010, v, a, l);
        check("t6_strb_ack", l, 1);
        rd_status(v);
        check("t6_no_push", v, 0);
        bus(BASE, 32'h0, 4'h0, v, a, l);
        check("t6_txdata_read", v, 0);
        repeat (300) @(negedge clk);
        check("frames_total", n_frames, n_push);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
